// File: rtl/legv8_control_unit.sv
// legv8_control_unit
//   Multi-cycle control unit for the LEGv8 datapath. Fetches an instruction
//   from RAM (F1/F2), latches it in the instruction register, then decodes it
//   in EX (plus LD2 for loads) and drives every datapath control input.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   INSTR           instruction word from DBUS[31:0], latched at the F2 edge
//   STAT_Z          ALU zero flag of the current cycle (used by CBZ only)
//   SA, SB, DA, WR  register selects and register file write enable
//   FS, C0, K, M    ALU function, carry-in, constant, B-input select
//   EN_ALU/EN_B/EN_PC            DBUS driver enables
//   EN_ADDR_ALU/EN_ADDR_PC       RAM address driver enables
//   PC_SEL, PS                   PC input select and PC operation
//   RCS, RWE, ROE                RAM strobes
//   SFL, HALTED, IR_Q            status load, halt indicator, IR contents
//
// Configuration
//   CU_CBZ_EN  when defined, CBZ is decoded; otherwise CBZ halts like any
//              unlisted opcode and STAT_Z is ignored.
module legv8_control_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTR,
  input  logic        STAT_Z,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic        WR,
  output logic [4:0]  FS,
  output logic        C0,
  output logic [63:0] K,
  output logic        M,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        EN_PC,
  output logic        EN_ADDR_ALU,
  output logic        EN_ADDR_PC,
  output logic        PC_SEL,
  output logic [1:0]  PS,
  output logic        RCS,
  output logic        RWE,
  output logic        ROE,
  output logic        SFL,
  output logic        HALTED,
  output logic [31:0] IR_Q
);

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;

  typedef enum logic [2:0] {ST_F1, ST_F2, ST_EX, ST_LD2, ST_HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_BAD
  } op_t;

  state_t      state_reg;
  logic [31:0] ir_reg;
  op_t         op;

  logic [4:0] rd, rn, rm;
  assign rd = ir_reg[4:0];
  assign rn = ir_reg[9:5];
  assign rm = ir_reg[20:16];

  // Opcode fields have different widths per format, so match longest first.
  always_comb begin
    op = OP_BAD;
    if (ir_reg == 32'h0)                     op = OP_BAD;
    else if (ir_reg[31:21] == 11'b10001011000) op = OP_ADD;
    else if (ir_reg[31:21] == 11'b11001011000) op = OP_SUB;
    else if (ir_reg[31:21] == 11'b10001010000) op = OP_AND;
    else if (ir_reg[31:21] == 11'b10101010000) op = OP_ORR;
    else if (ir_reg[31:21] == 11'b11111000010) op = OP_LDUR;
    else if (ir_reg[31:21] == 11'b11111000000) op = OP_STUR;
    else if (ir_reg[31:22] == 10'b1001000100)  op = OP_ADDI;
    else if (ir_reg[31:22] == 10'b1101000100)  op = OP_SUBI;
`ifdef CU_CBZ_EN
    else if (ir_reg[31:24] == 8'b10110100)     op = OP_CBZ;
`endif
    else if (ir_reg[31:26] == 6'b000101)       op = OP_B;
  end

`ifndef CU_CBZ_EN
  // STAT_Z has no consumer when CBZ is compiled out.
  logic unused_stat_z;
  assign unused_stat_z = STAT_Z;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_F1;
      ir_reg    <= 32'h0;
    end else begin
      unique case (state_reg)
        ST_F1:   state_reg <= ST_F2;
        ST_F2: begin
          ir_reg    <= INSTR;
          state_reg <= ST_EX;
        end
        ST_EX: begin
          if (op == OP_LDUR)     state_reg <= ST_LD2;
          else if (op == OP_BAD) state_reg <= ST_HALT;
          else                   state_reg <= ST_F1;
        end
        ST_LD2:  state_reg <= ST_F1;
        ST_HALT: state_reg <= ST_HALT;
        default: state_reg <= ST_F1;
      endcase
    end
  end

  assign IR_Q = ir_reg;

  always_comb begin
    SA = 5'd0; SB = 5'd0; DA = 5'd0; WR = 1'b0;
    FS = FS_ADD; C0 = 1'b0; K = 64'd0; M = 1'b0;
    EN_ALU = 1'b0; EN_B = 1'b0; EN_PC = 1'b0;
    EN_ADDR_ALU = 1'b0; EN_ADDR_PC = 1'b0;
    PC_SEL = 1'b0; PS = 2'b00;
    RCS = 1'b0; RWE = 1'b0; ROE = 1'b0; SFL = 1'b0; HALTED = 1'b0;

    unique case (state_reg)
      ST_F1, ST_F2: begin
        EN_ADDR_PC = 1'b1; RCS = 1'b1; ROE = 1'b1;
      end
      ST_EX: begin
        unique case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: begin
            SA = rn; SB = rm; DA = rd;
            EN_ALU = 1'b1; WR = 1'b1; PS = 2'b01;
            case (op)
              OP_SUB, OP_SUBI: FS = FS_SUB;
              OP_AND:          FS = FS_AND;
              OP_ORR:          FS = FS_ORR;
              default:         FS = FS_ADD;
            endcase
            C0  = (op == OP_SUB) || (op == OP_SUBI);
            SFL = (op == OP_ADD) || (op == OP_SUB);
            if ((op == OP_ADDI) || (op == OP_SUBI)) begin
              M = 1'b1;
              K = {52'd0, ir_reg[21:10]};
            end
          end
          OP_LDUR: begin
            SA = rn; M = 1'b1; K = {{55{ir_reg[20]}}, ir_reg[20:12]};
            EN_ADDR_ALU = 1'b1; RCS = 1'b1; ROE = 1'b1;
          end
          OP_STUR: begin
            SA = rn; M = 1'b1; K = {{55{ir_reg[20]}}, ir_reg[20:12]};
            EN_ADDR_ALU = 1'b1;
            SB = rd; EN_B = 1'b1; RCS = 1'b1; RWE = 1'b1; PS = 2'b01;
          end
          OP_B: begin
            PC_SEL = 1'b1; K = {{38{ir_reg[25]}}, ir_reg[25:0]}; PS = 2'b11;
          end
`ifdef CU_CBZ_EN
          OP_CBZ: begin
            // Test Rt + XZR so the zero flag is independent of K, which is
            // free to carry the branch offset to the PC input.
            SA = rd; SB = 5'd31; M = 1'b0;
            if (STAT_Z) begin
              PC_SEL = 1'b1; K = {{45{ir_reg[23]}}, ir_reg[23:5]}; PS = 2'b11;
            end else begin
              PS = 2'b01;
            end
          end
`endif
          default: ;
        endcase
      end
      ST_LD2: begin
        SA = rn; M = 1'b1; K = {{55{ir_reg[20]}}, ir_reg[20:12]};
        EN_ADDR_ALU = 1'b1; RCS = 1'b1; ROE = 1'b1;
        DA = rd; WR = 1'b1; PS = 2'b01;
      end
      ST_HALT: HALTED = 1'b1;
      default: ;
    endcase

    // X31 is the zero register; writes to it are discarded.
    if (DA == 5'd31) WR = 1'b0;
  end

endmodule

// File: tb/tb_legv8_control_unit.sv
module tb_legv8_control_unit;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_ADDI = 4,
                 K_SUBI = 5, K_LDUR = 6, K_STUR = 7, K_B = 8, K_CBZ = 9,
                 K_BAD = 10;

  logic        CLK, RST, STAT_Z;
  logic [31:0] INSTR;
  logic [4:0]  SA, SB, DA, FS;
  logic        WR, C0, M, EN_ALU, EN_B, EN_PC, EN_ADDR_ALU, EN_ADDR_PC;
  logic        PC_SEL, RCS, RWE, ROE, SFL, HALTED;
  logic [1:0]  PS;
  logic [63:0] K;
  logic [31:0] IR_Q;

  legv8_control_unit dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .STAT_Z(STAT_Z),
    .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0), .K(K), .M(M),
    .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_PC(EN_PC),
    .EN_ADDR_ALU(EN_ADDR_ALU), .EN_ADDR_PC(EN_ADDR_PC),
    .PC_SEL(PC_SEL), .PS(PS), .RCS(RCS), .RWE(RWE), .ROE(ROE),
    .SFL(SFL), .HALTED(HALTED), .IR_Q(IR_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] prev_ir;

  typedef struct {
    logic [4:0]  sa, sb, da, fs;
    logic        wr, c0, m, en_alu, en_b, en_pc, en_addr_alu, en_addr_pc;
    logic        pc_sel, rcs, rwe, roe, sfl, halted;
    logic [1:0]  ps;
    logic [63:0] k;
    logic [31:0] ir_q;
  } exp_t;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t idle(input logic [31:0] ir);
    exp_t e;
    e.sa = 0; e.sb = 0; e.da = 0; e.fs = FS_ADD;
    e.wr = 0; e.c0 = 0; e.m = 0; e.en_alu = 0; e.en_b = 0; e.en_pc = 0;
    e.en_addr_alu = 0; e.en_addr_pc = 0; e.pc_sel = 0; e.rcs = 0;
    e.rwe = 0; e.roe = 0; e.sfl = 0; e.halted = 0; e.ps = 0; e.k = 0;
    e.ir_q = ir;
    return e;
  endfunction

  function automatic exp_t fetch(input logic [31:0] ir);
    exp_t e = idle(ir);
    e.en_addr_pc = 1; e.rcs = 1; e.roe = 1;
    return e;
  endfunction

  task automatic compare(input exp_t e, input string ph);
    check_val({ph, ".SA"}, SA, e.sa);
    check_val({ph, ".SB"}, SB, e.sb);
    check_val({ph, ".DA"}, DA, e.da);
    check_val({ph, ".WR"}, WR, e.wr);
    check_val({ph, ".FS"}, FS, e.fs);
    check_val({ph, ".C0"}, C0, e.c0);
    check_val({ph, ".K"}, K, e.k);
    check_val({ph, ".M"}, M, e.m);
    check_val({ph, ".EN_ALU"}, EN_ALU, e.en_alu);
    check_val({ph, ".EN_B"}, EN_B, e.en_b);
    check_val({ph, ".EN_PC"}, EN_PC, e.en_pc);
    check_val({ph, ".EN_ADDR_ALU"}, EN_ADDR_ALU, e.en_addr_alu);
    check_val({ph, ".EN_ADDR_PC"}, EN_ADDR_PC, e.en_addr_pc);
    check_val({ph, ".PC_SEL"}, PC_SEL, e.pc_sel);
    check_val({ph, ".PS"}, PS, e.ps);
    check_val({ph, ".RCS"}, RCS, e.rcs);
    check_val({ph, ".RWE"}, RWE, e.rwe);
    check_val({ph, ".ROE"}, ROE, e.roe);
    check_val({ph, ".SFL"}, SFL, e.sfl);
    check_val({ph, ".HALTED"}, HALTED, e.halted);
    check_val({ph, ".IR_Q"}, IR_Q, e.ir_q);
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases at a
  // falling edge so the next rising edge is the first F1 -> F2 step.
  task automatic do_reset();
    RST = 1'b0;
    #1;
    compare(fetch(32'h0), "rst");
    prev_ir = 32'h0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // Runs one instruction from its F1 cycle onwards. Expected behaviour is
  // derived from the instruction class and its operand values.
  task automatic run(input int kind, input logic [4:0] rd, input logic [4:0] rn,
                     input logic [4:0] rm, input longint imm, input bit z,
                     input logic [31:0] raw, input bit abort_ld2);
    logic [31:0] w;
    logic [63:0] iv;
    exp_t q[$];
    exp_t e;
    bit halts;
    string ph;
    iv = imm;
    case (kind)
      K_ADD:  w = {OPC_ADD, rm, 6'd0, rn, rd};
      K_SUB:  w = {OPC_SUB, rm, 6'd0, rn, rd};
      K_AND:  w = {OPC_AND, rm, 6'd0, rn, rd};
      K_ORR:  w = {OPC_ORR, rm, 6'd0, rn, rd};
      K_ADDI: w = {OPC_ADDI, iv[11:0], rn, rd};
      K_SUBI: w = {OPC_SUBI, iv[11:0], rn, rd};
      K_LDUR: w = {OPC_LDUR, iv[8:0], 2'b00, rn, rd};
      K_STUR: w = {OPC_STUR, iv[8:0], 2'b00, rn, rd};
      K_B:    w = {OPC_B, iv[25:0]};
      K_CBZ:  w = {OPC_CBZ, iv[18:0], rd};
      default: w = raw;
    endcase
    INSTR  = w;
    STAT_Z = z;
`ifdef CU_CBZ_EN
    halts = (kind == K_BAD);
`else
    halts = (kind == K_BAD) || (kind == K_CBZ);
`endif
    q.push_back(fetch(prev_ir));
    q.push_back(fetch(prev_ir));
    e = idle(w);
    if (!halts) begin
      case (kind)
        K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI: begin
          e.sa = rn; e.sb = w[20:16]; e.da = rd;
          e.en_alu = 1; e.wr = (rd != 31); e.ps = 1;
          e.fs = (kind == K_SUB || kind == K_SUBI) ? FS_SUB :
                 (kind == K_AND) ? FS_AND : (kind == K_ORR) ? FS_ORR : FS_ADD;
          e.c0 = (kind == K_SUB || kind == K_SUBI);
          e.sfl = (kind == K_ADD || kind == K_SUB);
          if (kind == K_ADDI || kind == K_SUBI) begin
            e.m = 1; e.k = imm;
          end
        end
        K_LDUR, K_STUR: begin
          e.sa = rn; e.m = 1; e.k = imm; e.en_addr_alu = 1; e.rcs = 1;
          if (kind == K_STUR) begin
            e.sb = rd; e.en_b = 1; e.rwe = 1; e.ps = 1;
          end else begin
            e.roe = 1;
          end
        end
        K_B: begin
          e.pc_sel = 1; e.k = imm; e.ps = 3;
        end
        K_CBZ: begin
          e.sa = rd; e.sb = 31; e.m = 0;
          if (z) begin
            e.pc_sel = 1; e.k = imm; e.ps = 3;
          end else begin
            e.ps = 1;
          end
        end
        default: ;
      endcase
    end
    q.push_back(e);
    if (kind == K_LDUR) begin
      e.da = rd; e.wr = (rd != 31); e.ps = 1;
      q.push_back(e);
    end
    if (halts) begin
      e = idle(w);
      e.halted = 1;
      for (int i = 0; i < 10; i++) q.push_back(e);
    end
    for (int i = 0; i < q.size(); i++) begin
      ph = $sformatf("k%0d.c%0d", kind, i);
      compare(q[i], ph);
      if (abort_ld2 && i == 3) begin
        #2;
        do_reset();
        return;
      end
      @(posedge CLK);
      #1;
    end
    $display("instr kind=%0d word=%08h z=%0b cycles=%0d errors=%0d",
             kind, w, z, q.size(), n_errors);
    prev_ir = w;
    if (halts) do_reset();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] raw;
    logic [5:0]  top;
    int kind;
    longint imm;
    RST = 1'b0; INSTR = 32'h0; STAT_Z = 1'b0; prev_ir = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    compare(fetch(32'h0), "reset");
    @(negedge CLK);
    RST = 1'b1;

    // Directed cases
    run(K_ADDI, 5'd1, 5'd31, 5'd0, 64'sd5, 1'b0, 32'h0, 1'b0);
    run(K_SUB,  5'd3, 5'd1, 5'd2, 0, 1'b0, 32'h0, 1'b0);
    run(K_LDUR, 5'd4, 5'd1, 5'd0, -2, 1'b0, 32'h0, 1'b0);
    run(K_CBZ,  5'd5, 5'd0, 5'd0, 3, 1'b1, 32'h0, 1'b0);
    run(K_CBZ,  5'd5, 5'd0, 5'd0, 3, 1'b0, 32'h0, 1'b0);
    run(K_ADD,  5'd31, 5'd1, 5'd2, 0, 1'b0, 32'h0, 1'b0);
    run(K_B,    5'd0, 5'd0, 5'd0, -33554432, 1'b0, 32'h0, 1'b0);
    run(K_BAD,  5'd0, 5'd0, 5'd0, 0, 1'b0, 32'h0, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 10);
      if (kind == K_BAD && $urandom_range(0, 2) != 0) kind = K_ADD;
      case (kind)
        K_ADDI, K_SUBI: imm = longint'($urandom_range(0, 4095));
        K_LDUR, K_STUR: imm = longint'($urandom_range(0, 511)) - 256;
        K_B:   imm = longint'($urandom_range(0, 67108863)) - 33554432;
        K_CBZ: imm = longint'($urandom_range(0, 524287)) - 262144;
        default: imm = 0;
      endcase
      r = $urandom;
      top = ($urandom_range(0, 1) != 0) ? 6'b111111 : 6'b000000;
      raw = ($urandom_range(0, 3) == 0) ? 32'h0 : {top, r[25:0]};
      run(kind, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), imm, 1'($urandom_range(0, 1)), raw, 1'b0);
    end

    // Reset asserted during LD2 aborts the load
    run(K_LDUR, 5'd7, 5'd2, 5'd0, 17, 1'b0, 32'h0, 1'b1);
    run(K_ADDI, 5'd2, 5'd3, 5'd0, 64'sd4095, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
